// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: instruction classes, immediate formats, opcode constants.
package riscv_pkg;

  typedef enum logic [3:0] {
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_ALU_IMM,
    OP_ALU_REG,
    OP_FENCE,
    OP_SYSTEM,
    OP_ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate extraction; the opcode bits [6:0] never carry immediate data.
module riscv_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  // Reassemble and sign-extend the immediate for the selected format.
  always_comb begin
    imm = 32'h0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_idu.sv
// RV32I instruction decode unit: one registered stage with valid/ready handshake and flush.
module riscv_idu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [29:0] pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [29:0] pc_o,
  output op_class_e   op_class_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  op_class_e   cls;
  imm_fmt_e    fmt;
  logic [4:0]  rd_dec;
  logic        r1u;
  logic        r2u;
  logic        ill;
  logic [31:0] imm_dec;
  logic        accept;

  logic        vld_p0;
  logic [29:0] pc_p0;
  op_class_e   cls_p0;
  logic [4:0]  rd_p0;
  logic [4:0]  rs1_p0;
  logic [4:0]  rs2_p0;
  logic        r1u_p0;
  logic        r2u_p0;
  logic [2:0]  f3_p0;
  logic        f7b5_p0;
  logic [31:0] imm_p0;
  logic        ill_p0;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign instr_ready_o = !vld_p0 || ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  riscv_imm_gen u_imm_gen (
    .instr (instr_i[31:7]),
    .fmt   (fmt),
    .imm   (imm_dec)
  );

  // Classify the opcode, pick the immediate format, flag illegal encodings.
  always_comb begin
    cls    = OP_ILLEGAL;
    fmt    = IMM_NONE;
    rd_dec = instr_i[11:7];
    r1u    = 1'b0;
    r2u    = 1'b0;
    ill    = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        OPC_LUI:   begin cls = OP_LUI;   fmt = IMM_U; end
        OPC_AUIPC: begin cls = OP_AUIPC; fmt = IMM_U; end
        OPC_JAL:   begin cls = OP_JAL;   fmt = IMM_J; end
        OPC_JALR: begin
          cls = OP_JALR; fmt = IMM_I; r1u = 1'b1;
          if (f3 != 3'd0) ill = 1'b1;
        end
        OPC_BRANCH: begin
          cls = OP_BRANCH; fmt = IMM_B; r1u = 1'b1; r2u = 1'b1;
          if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        end
        OPC_LOAD: begin
          cls = OP_LOAD; fmt = IMM_I; r1u = 1'b1;
          if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ill = 1'b1;
        end
        OPC_STORE: begin
          cls = OP_STORE; fmt = IMM_S; r1u = 1'b1; r2u = 1'b1;
          if (f3 > 3'd2) ill = 1'b1;
        end
        OPC_OP_IMM: begin
          cls = OP_ALU_IMM; fmt = IMM_I; r1u = 1'b1;
          // Shift-immediates reuse the upper immediate bits as funct7.
          if (f3 == 3'b001 && f7 != 7'h00) ill = 1'b1;
          if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        end
        OPC_OP: begin
          cls = OP_ALU_REG; r1u = 1'b1; r2u = 1'b1;
          if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
          if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
        end
        OPC_MISC_MEM: begin cls = OP_FENCE;  fmt = IMM_I; end
        OPC_SYSTEM:   begin cls = OP_SYSTEM; fmt = IMM_I; end
        default: ill = 1'b1;
      endcase
    end
    // Illegal words travel downstream as inert bubbles that write and read nothing.
    if (ill) begin
      cls = OP_ILLEGAL;
      fmt = IMM_NONE;
      r1u = 1'b0;
      r2u = 1'b0;
    end
    if (ill || cls == OP_BRANCH || cls == OP_STORE || cls == OP_FENCE) rd_dec = 5'd0;
  end

  // Output register: flush beats accept, accept beats a plain consume.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p0  <= 1'b0;
      pc_p0   <= '0;
      cls_p0  <= OP_ILLEGAL;
      rd_p0   <= '0;
      rs1_p0  <= '0;
      rs2_p0  <= '0;
      r1u_p0  <= 1'b0;
      r2u_p0  <= 1'b0;
      f3_p0   <= '0;
      f7b5_p0 <= 1'b0;
      imm_p0  <= '0;
      ill_p0  <= 1'b0;
    end else if (flush_i) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      pc_p0   <= pc_i;
      cls_p0  <= cls;
      rd_p0   <= rd_dec;
      rs1_p0  <= instr_i[19:15];
      rs2_p0  <= instr_i[24:20];
      r1u_p0  <= r1u;
      r2u_p0  <= r2u;
      f3_p0   <= f3;
      f7b5_p0 <= instr_i[30];
      imm_p0  <= imm_dec;
      ill_p0  <= ill;
    end else if (vld_p0 && ready_i) begin
      vld_p0 <= 1'b0;
    end
  end

  assign valid_o    = vld_p0;
  assign pc_o       = pc_p0;
  assign op_class_o = cls_p0;
  assign rd_o       = rd_p0;
  assign rs1_o      = rs1_p0;
  assign rs2_o      = rs2_p0;
  assign rs1_used_o = r1u_p0;
  assign rs2_used_o = r2u_p0;
  assign funct3_o   = f3_p0;
  assign funct7b5_o = f7b5_p0;
  assign imm_o      = imm_p0;
  assign illegal_o  = ill_p0;

endmodule

// File: tb/tb_riscv_idu.sv
// Directed bench for riscv_idu with hand-computed expected decode results.
module tb_riscv_idu;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [29:0] pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [29:0] pc_o;
  op_class_e   op_class_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic        rs1_used_o;
  logic        rs2_used_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  int total = 0;
  int bad   = 0;

  riscv_idu dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .op_class_o    (op_class_o),
    .rd_o          (rd_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rs1_used_o    (rs1_used_o),
    .rs2_used_o    (rs2_used_o),
    .funct3_o      (funct3_o),
    .funct7b5_o    (funct7b5_o),
    .imm_o         (imm_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [29:0] pc,
                       input logic rdy, input logic fl);
    @(negedge clk_i);
    instr_valid_i = v;
    instr_i       = ins;
    pc_i          = pc;
    ready_i       = rdy;
    flush_i       = fl;
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0;
    instr_i = 32'h0; pc_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_class", {28'd0, op_class_o}, {28'd0, OP_ILLEGAL});
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("rst_ready", {31'd0, instr_ready_o}, 32'd1);

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 30'h10, 1'b1, 1'b0);
    tick();
    chk("addi_valid", {31'd0, valid_o}, 32'd1);
    chk("addi_class", {28'd0, op_class_o}, {28'd0, OP_ALU_IMM});
    chk("addi_rd", {27'd0, rd_o}, 32'd1);
    chk("addi_rs1", {27'd0, rs1_o}, 32'd0);
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_pc", {2'b0, pc_o}, 32'h10);
    chk("addi_rs2u", {31'd0, rs2_used_o}, 32'd0);

    // sw x2,-4(x1)
    drive(1'b1, 32'hFE20AE23, 30'h11, 1'b1, 1'b0);
    tick();
    chk("sw_class", {28'd0, op_class_o}, {28'd0, OP_STORE});
    chk("sw_rs1", {27'd0, rs1_o}, 32'd1);
    chk("sw_rs2", {27'd0, rs2_o}, 32'd2);
    chk("sw_rd", {27'd0, rd_o}, 32'd0);
    chk("sw_imm", imm_o, 32'hFFFFFFFC);
    chk("sw_rs2u", {31'd0, rs2_used_o}, 32'd1);
    chk("sw_f3", {29'd0, funct3_o}, 32'd2);

    // jal x0,-8
    drive(1'b1, 32'hFF9FF06F, 30'h12, 1'b1, 1'b0);
    tick();
    chk("jal_class", {28'd0, op_class_o}, {28'd0, OP_JAL});
    chk("jal_imm", imm_o, 32'hFFFFFFF8);
    chk("jal_rd", {27'd0, rd_o}, 32'd0);
    chk("jal_rs1u", {31'd0, rs1_used_o}, 32'd0);

    // all-zero word
    drive(1'b1, 32'h00000000, 30'h13, 1'b1, 1'b0);
    tick();
    chk("zero_valid", {31'd0, valid_o}, 32'd1);
    chk("zero_ill", {31'd0, illegal_o}, 32'd1);
    chk("zero_class", {28'd0, op_class_o}, {28'd0, OP_ILLEGAL});
    chk("zero_rd", {27'd0, rd_o}, 32'd0);

    // beq x1,x2,+8
    drive(1'b1, 32'h00208463, 30'h14, 1'b1, 1'b0);
    tick();
    chk("beq_class", {28'd0, op_class_o}, {28'd0, OP_BRANCH});
    chk("beq_imm", imm_o, 32'd8);
    chk("beq_rd", {27'd0, rd_o}, 32'd0);
    chk("beq_rs2u", {31'd0, rs2_used_o}, 32'd1);

    // lui x5,0x12345
    drive(1'b1, 32'h123452B7, 30'h15, 1'b1, 1'b0);
    tick();
    chk("lui_class", {28'd0, op_class_o}, {28'd0, OP_LUI});
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_rd", {27'd0, rd_o}, 32'd5);
    chk("lui_rs1u", {31'd0, rs1_used_o}, 32'd0);

    // sub x3,x1,x2
    drive(1'b1, 32'h402081B3, 30'h16, 1'b1, 1'b0);
    tick();
    chk("sub_class", {28'd0, op_class_o}, {28'd0, OP_ALU_REG});
    chk("sub_f7b5", {31'd0, funct7b5_o}, 32'd1);
    chk("sub_rd", {27'd0, rd_o}, 32'd3);
    chk("sub_ill", {31'd0, illegal_o}, 32'd0);

    // funct7=0x20 with OR: illegal
    drive(1'b1, 32'h4020E1B3, 30'h17, 1'b1, 1'b0);
    tick();
    chk("or20_ill", {31'd0, illegal_o}, 32'd1);
    chk("or20_rd", {27'd0, rd_o}, 32'd0);

    // mul x1,x2,x3 (funct7=0x01): not RV32I
    drive(1'b1, 32'h023100B3, 30'h18, 1'b1, 1'b0);
    tick();
    chk("mul_ill", {31'd0, illegal_o}, 32'd1);
    chk("mul_class", {28'd0, op_class_o}, {28'd0, OP_ILLEGAL});
    chk("mul_rd", {27'd0, rd_o}, 32'd0);

    // slli with nonzero funct7: illegal shift
    drive(1'b1, 32'h02109093, 30'h19, 1'b1, 1'b0);
    tick();
    chk("slli_ill", {31'd0, illegal_o}, 32'd1);

    // Back-pressure: A accepted, then B waits for 3 stalled cycles.
    drive(1'b1, 32'h00A00093, 30'h20, 1'b1, 1'b0);
    tick();
    chk("stall_a_pc", {2'b0, pc_o}, 32'h20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00B00113, 30'h21, 1'b0, 1'b0);
      #1;
      chk("stall_rdy", {31'd0, instr_ready_o}, 32'd0);
      tick();
      chk("stall_valid", {31'd0, valid_o}, 32'd1);
      chk("stall_pc", {2'b0, pc_o}, 32'h20);
      chk("stall_imm", imm_o, 32'd10);
      chk("stall_rd", {27'd0, rd_o}, 32'd1);
    end
    drive(1'b1, 32'h00B00113, 30'h21, 1'b1, 1'b0);
    tick();
    chk("order_b_pc", {2'b0, pc_o}, 32'h21);
    chk("order_b_imm", imm_o, 32'd11);
    drive(1'b1, 32'h00C00193, 30'h22, 1'b1, 1'b0);
    tick();
    chk("order_c_pc", {2'b0, pc_o}, 32'h22);
    chk("order_c_rd", {27'd0, rd_o}, 32'd3);
    drive(1'b0, 32'h0, 30'h0, 1'b1, 1'b0);
    tick();
    chk("drain_valid", {31'd0, valid_o}, 32'd0);

    // Flush while one is held and another is offered.
    drive(1'b1, 32'h00D00213, 30'h30, 1'b0, 1'b0);
    tick();
    chk("fl_held", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 32'h00E00293, 30'h31, 1'b1, 1'b1);
    tick();
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    drive(1'b0, 32'h0, 30'h0, 1'b1, 1'b0);
    tick();
    chk("fl_after", {31'd0, valid_o}, 32'd0);

    // Asynchronous reset while an instruction is stalled.
    drive(1'b1, 32'h00F00313, 30'h40, 1'b0, 1'b0);
    tick();
    chk("ar_held", {31'd0, valid_o}, 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("ar_valid", {31'd0, valid_o}, 32'd0);
    chk("ar_pc", {2'b0, pc_o}, 32'd0);
    chk("ar_class", {28'd0, op_class_o}, {28'd0, OP_ILLEGAL});
    instr_valid_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("ar_ready", {31'd0, instr_ready_o}, 32'd1);
    tick();
    chk("ar_stay", {31'd0, valid_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_idu.md
RISCV_IDU -- requirements
Module: riscv_idu

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1 bit: reset; asynchronous, active-high.
REQ-004 The block SHALL have port flush_i, input, 1 bit: discard the held instruction (branch or jump redirect).
REQ-005 The block SHALL have port instr_valid_i, input, 1 bit: fetch stage presents an instruction.
REQ-006 The block SHALL have port instr_ready_o, output, 1 bit: the block accepts the instruction this cycle.
REQ-007 The block SHALL have port instr_i, input, 32 bits: raw instruction word.
REQ-008 The block SHALL have port pc_i, input, 30 bits: word address of instr_i.
REQ-009 The block SHALL have port valid_o, output, 1 bit: decoded instruction is presented to execute.
REQ-010 The block SHALL have port ready_i, input, 1 bit: execute consumes the decoded instruction.
REQ-011 The block SHALL have port pc_o, output, 30 bits: word PC of the decoded instruction.
REQ-012 The block SHALL have port op_class_o, output, op_class_e: instruction class.
REQ-013 The block SHALL have ports rd_o, rs1_o and rs2_o, output, 5 bits each: register indices.
REQ-014 The block SHALL have ports rs1_used_o and rs2_used_o, output, 1 bit each: source register is read.
REQ-015 The block SHALL have port funct3_o, output, 3 bits, and port funct7b5_o, output, 1 bit: ALU or branch qualifiers.
REQ-016 The block SHALL have port imm_o, output, 32 bits: sign-extended immediate.
REQ-017 The block SHALL have port illegal_o, output, 1 bit: the instruction is not valid RV32I.

Function
REQ-018 The block SHALL hold a single output register. Handshake: instr_ready_o = !valid_o || ready_i (combinational). An instruction is accepted when instr_valid_i && instr_ready_o.
REQ-019 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented with valid_o=1 after edge N.
REQ-020 While valid_o && !ready_i, all outputs SHALL hold stable.
REQ-021 Accept and consume in the same cycle SHALL replace the register, giving full throughput with no bubble.
REQ-022 On flush_i=1, valid_o SHALL be 0 after the edge. An instruction presented in the same cycle as flush_i SHALL be discarded. Flush has priority over accept and consume.
REQ-023 Immediate formats I/S/B/U/J SHALL follow RV32I. B and J immediates are byte offsets with bit0=0. U immediates place instr[31:12] in bits [31:12] with the low bits zero.
REQ-024 rd_o SHALL be forced to 0 for BRANCH, STORE, FENCE and illegal instructions.
REQ-025 rs1_used_o SHALL be 0 for LUI, AUIPC, JAL, FENCE and SYSTEM. rs2_used_o SHALL be 1 only for BRANCH, STORE and ALU_REG.
REQ-026 illegal_o SHALL be 1 under any of these conditions:
- instr[1:0] != 2'b11;
- unknown opcode;
- JALR with funct3 != 0;
- BRANCH with funct3 of 2 or 3;
- LOAD with funct3 of 3, 6 or 7;
- STORE with funct3 > 2;
- OP-IMM shift with illegal funct7;
- OP with funct7 not in {0x00, 0x20}, or 0x20 with a funct3 other than ADD/SRL.
REQ-027 An illegal instruction SHALL be passed downstream with op_class_o=OP_ILLEGAL and illegal_o=1. It SHALL NOT be dropped.

Reset
REQ-028 On reset_i, valid_o SHALL be 0 and every other registered output SHALL be 0, with op_class_o=OP_ILLEGAL. reset_i SHALL take effect immediately, without waiting for a clock edge.
REQ-029 Reset mid-handshake SHALL discard the held instruction. After release, instr_ready_o=1.

Structure
REQ-030 The riscv_pkg package SHALL hold:
- op_class_e, with members OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALU_IMM, OP_ALU_REG, OP_FENCE, OP_SYSTEM, OP_ILLEGAL;
- the 7-bit opcode constants.
REQ-031 Immediate extraction SHALL be a combinational sub-module, riscv_imm_gen, taking instr and format and producing imm.

Verification
REQ-032 The bench SHALL present instr 0x00500093 (addi x1,x0,5), pc 0x10, with ready_i=1. Required response, next cycle: valid_o=1, OP_ALU_IMM, rd=1, rs1=0, imm=5, pc_o=0x10.
REQ-033 The bench SHALL present instr 0xFE20AE23 (sw x2,-4(x1)). Required response: OP_STORE, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC, rs2_used_o=1.
REQ-034 The bench SHALL present instr 0xFF9FF06F (jal x0,-8). Required response: OP_JAL, imm=0xFFFFFFF8, rd=0, rs1_used_o=0.
REQ-035 The bench SHALL present instr 0x00000000. Required response: valid_o=1, illegal_o=1, OP_ILLEGAL, rd=0.
REQ-036 The bench SHALL hold ready_i=0 for 3 cycles with a back-to-back stream. Required response: outputs stable, instr_ready_o=0. After ready_i rises, each instruction appears exactly once and in order.
REQ-037 The bench SHALL assert flush_i while valid_o=1 and instr_valid_i=1. Required response: next cycle valid_o=0, and both instructions are never presented.
